led_pattern_seq: RTL and testbench

- Parametrised LED pattern sequencer driving an N-bit LED bank from single-cycle button pulses.
- Five selectable animation modes, run-time speed selection and pause/resume.
- Built-in prescaler generates the step tick.
- Sits between the board-level debounce instances (one per button) and the LED pins. It supersedes the fixed 4-LED, 3-pattern controller.

---
 rtl/led_pkg.sv | 27 ++
 rtl/led_tick_gen.sv | 31 +++
 rtl/led_pattern_seq.sv | 101 ++++++++++
 tb/tb_led_pattern_seq.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern sequencer: mode codes and the
// per-mode step period.
package led_pkg;

  typedef enum logic [2:0] {
    MODE_BOUNCE = 3'd0,
    MODE_LEFT   = 3'd1,
    MODE_RIGHT  = 3'd2,
    MODE_FILL   = 3'd3,
    MODE_BLINK  = 3'd4
  } mode_t;

  localparam int NUM_MODES = 5;

  // Number of distinct steps a mode cycles through before wrapping to 0.
  function automatic int mode_period(input mode_t m, input int n_led);
    case (m)
      MODE_BOUNCE: return 2 * n_led - 2;
      MODE_LEFT:   return n_led;
      MODE_RIGHT:  return n_led;
      MODE_FILL:   return n_led + 1;
      MODE_BLINK:  return 2;
      default:     return 1;
    endcase
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step-tick prescaler: a free-running counter that only advances while enabled;
// higher speed levels look at fewer low bits, halving the tick period each level.
module led_tick_gen #(
  parameter int DIV_W = 23,
  parameter int SPD_W = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic             clr,
  input  logic [SPD_W-1:0] speed,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] mask;

  assign mask = {DIV_W{1'b1}} >> speed;
  assign tick = en && ((cnt & mask) == mask);

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: button pulses pick the mode, speed and run state;
// the LED bank is a combinational decode of the registered mode and step.
module led_pattern_seq
  import led_pkg::*;
#(
  parameter int N_LED = 4,
  parameter int DIV_W = 23,
  parameter int SPD_W = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             UP,
  input  logic             DOWN,
  input  logic             SPEED,
  input  logic             PAUSE,
  output logic [N_LED-1:0] LED,
  output logic [2:0]       MODE,
  output logic             RUN
);

  localparam int SW = $clog2(2 * N_LED);

  mode_t            mode;
  mode_t            mode_next;
  logic [SW-1:0]    step;
  logic [SW-1:0]    step_last;
  logic [SW-1:0]    pos;
  logic [SPD_W-1:0] speed;
  logic             run;
  logic             tick;
  logic             mode_chg;

  // Pressing UP and DOWN together cancels out and leaves everything alone.
  assign mode_chg  = UP ^ DOWN;
  assign step_last = SW'(mode_period(mode, N_LED) - 1);

  always_comb begin
    mode_next = mode;
    if (UP) begin
      mode_next = (mode == MODE_BLINK) ? MODE_BOUNCE : mode_t'(mode + 3'd1);
    end else if (DOWN) begin
      mode_next = (mode == MODE_BOUNCE) ? MODE_BLINK : mode_t'(mode - 3'd1);
    end
  end

  led_tick_gen #(
    .DIV_W(DIV_W),
    .SPD_W(SPD_W)
  ) u_tick (
    .CLK  (CLK),
    .RST  (RST),
    .en   (run),
    .clr  (mode_chg | SPEED),
    .speed(speed),
    .tick (tick)
  );

  // A mode change restarts the animation and swallows any coincident tick.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mode  <= MODE_BOUNCE;
      step  <= '0;
      speed <= '0;
      run   <= 1'b1;
    end else begin
      if (PAUSE) begin
        run <= ~run;
      end
      if (SPEED) begin
        speed <= speed + 1'b1;
      end
      if (mode_chg) begin
        mode <= mode_next;
        step <= '0;
      end else if (tick) begin
        step <= (step == step_last) ? '0 : step + 1'b1;
      end
    end
  end

  always_comb begin
    LED = '0;
    pos = '0;
    case (mode)
      MODE_BOUNCE: begin
        pos = (step < SW'(N_LED)) ? step : SW'(2 * N_LED - 2) - step;
        LED = N_LED'(1) << pos;
      end
      MODE_LEFT:  LED = N_LED'(1) << step;
      MODE_RIGHT: LED = N_LED'(1) << (SW'(N_LED - 1) - step);
      // Shifting all ones out entirely at step N_LED yields the full bar.
      MODE_FILL:  LED = ~({N_LED{1'b1}} << step);
      MODE_BLINK: LED = (step == '0) ? {N_LED{1'b1}} : '0;
      default:    LED = '0;
    endcase
  end

  assign MODE = mode;
  assign RUN  = run;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Scoreboard bench for led_pattern_seq (N_LED=4, DIV_W=4, SPD_W=2): a table-driven
// reference model queues the expected {LED,MODE,RUN} every cycle.
module tb_led_pattern_seq;

  logic       CLK;
  logic       RST;
  logic       UP;
  logic       DOWN;
  logic       SPEED;
  logic       PAUSE;
  logic [3:0] LED;
  logic [2:0] MODE;
  logic       RUN;

  int checks   = 0;
  int failures = 0;

  logic [7:0] expQ[$];

  int bounceTab[6] = '{1, 2, 4, 8, 4, 2};
  int leftTab[4]   = '{1, 2, 4, 8};
  int rightTab[4]  = '{8, 4, 2, 1};
  int fillTab[5]   = '{0, 1, 3, 7, 15};
  int blinkTab[2]  = '{15, 0};
  int periodTab[5] = '{6, 4, 4, 5, 2};

  int mMode, mStep, mSpeed, mPresc;
  bit mRun;
  bit found;

  led_pattern_seq #(
    .N_LED(4),
    .DIV_W(4),
    .SPD_W(2)
  ) dut (
    .CLK  (CLK),
    .RST  (RST),
    .UP   (UP),
    .DOWN (DOWN),
    .SPEED(SPEED),
    .PAUSE(PAUSE),
    .LED  (LED),
    .MODE (MODE),
    .RUN  (RUN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic int expLed();
    case (mMode)
      0:       return bounceTab[mStep];
      1:       return leftTab[mStep];
      2:       return rightTab[mStep];
      3:       return fillTab[mStep];
      default: return blinkTab[mStep];
    endcase
  endfunction

  function automatic bit modelTick();
    int mask;
    mask = (1 << (4 - mSpeed)) - 1;
    return mRun && ((mPresc & mask) == mask);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drives one cycle of inputs, advances the model, then checks the DUT after the edge.
  task automatic applyStimulus(input bit r, input bit u, input bit d, input bit s, input bit p);
    bit         t;
    logic [3:0] el;
    logic [7:0] got;
    logic [7:0] exp;
    RST = r; UP = u; DOWN = d; SPEED = s; PAUSE = p;
    if (r) begin
      mMode = 0; mStep = 0; mSpeed = 0; mPresc = 0; mRun = 1'b1;
    end else begin
      t = modelTick();
      if (u ^ d) begin
        mMode  = u ? (mMode + 1) % 5 : (mMode + 4) % 5;
        mStep  = 0;
        mPresc = 0;
      end else begin
        if (t) mStep = (mStep + 1) % periodTab[mMode];
        if (s) mPresc = 0;
        else if (mRun) mPresc = (mPresc + 1) % 16;
      end
      if (s) mSpeed = (mSpeed + 1) % 4;
      if (p) mRun = !mRun;
    end
    el = 4'(expLed());
    expQ.push_back({el, 3'(mMode), mRun});
    @(posedge CLK);
    #1;
    got = {LED, MODE, RUN};
    exp = expQ.pop_front();
    checkOutput("cycle", got, exp);
    RST = 1'b0; UP = 1'b0; DOWN = 1'b0; SPEED = 1'b0; PAUSE = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
  endtask

  initial begin
    RST = 1'b1; UP = 1'b0; DOWN = 1'b0; SPEED = 1'b0; PAUSE = 1'b0;
    @(posedge CLK);
    #1;

    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("reset_led", LED, 4'b0001);
    checkOutput("reset_mode", MODE, 3'd0);
    checkOutput("reset_run", RUN, 1'b1);
    idle(160);

    // UP in the middle of bounce step 3
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (mStep == 3 && mMode == 0) found = 1;
      else applyStimulus(0, 0, 0, 0, 0);
    end
    checkOutput("wait_step3", found, 1);
    idle(5);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("up_mode", MODE, 3'd1);
    checkOutput("up_led", LED, 4'b0001);
    idle(16);
    checkOutput("left_step1", LED, 4'b0010);
    applyStimulus(0, 1, 0, 0, 0);
    idle(3);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("fill_mode", MODE, 3'd3);
    idle(100);

    // Wrap up to BOUNCE, then DOWN wraps to BLINK, then UP+DOWN together
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("wrap_up", MODE, 3'd0);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("wrap_down", MODE, 3'd4);
    idle(40);
    applyStimulus(0, 1, 1, 0, 0);
    idle(20);

    // Speed levels, then a speed press exactly on a tick
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 0, 1, 0);
      idle(20);
    end
    applyStimulus(0, 0, 0, 1, 0);
    idle(40);
    applyStimulus(0, 0, 0, 1, 0);
    idle(7);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (modelTick()) found = 1;
      else applyStimulus(0, 0, 0, 0, 0);
    end
    checkOutput("wait_tick_speed", found, 1);
    applyStimulus(0, 0, 0, 1, 0);
    idle(10);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    idle(10);

    // Pause on LED=0100 in BOUNCE, change mode while frozen, then resume
    applyStimulus(0, 1, 0, 0, 0);
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (expLed() == 4 && !modelTick()) found = 1;
      else applyStimulus(0, 0, 0, 0, 0);
    end
    checkOutput("wait_led0100", found, 1);
    applyStimulus(0, 0, 0, 0, 1);
    idle(100);
    checkOutput("pause_led", LED, 4'b0100);
    checkOutput("pause_run", RUN, 1'b0);
    applyStimulus(0, 1, 0, 0, 0);
    idle(20);
    checkOutput("pause_up_led", LED, 4'b0001);
    applyStimulus(0, 0, 0, 0, 1);
    idle(40);

    // Reset coinciding with UP and a tick
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (modelTick()) found = 1;
      else applyStimulus(0, 0, 0, 0, 0);
    end
    checkOutput("wait_tick_rst", found, 1);
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("rst_led", LED, 4'b0001);
    checkOutput("rst_mode", MODE, 3'd0);
    checkOutput("rst_run", RUN, 1'b1);
    idle(40);

    checkOutput("queue_empty", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
